// File: rtl/tick_rate_ctrl_pkg.sv
// Shared definitions for the tick rate controller: FSM encoding and division limits.
package tick_rate_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // 250000 cycles of 50 MHz gives a 100 Hz clk_out (two ticks per clk_out period).
    localparam int DEFAULT_DIV = 250000;

    // Smallest usable period; anything shorter is raised to this.
    localparam int MIN_DIV = 2;

endpackage

// File: rtl/tick_rate_ctrl_tick_counter.sv
// Period counter: clear has priority over increment; tc flags the last cycle of a period.
module tick_counter
    import tick_rate_ctrl_pkg::*;
#(
    parameter int CNT_W = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             tc
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: restart from zero on clear, otherwise advance when enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // div is never below MIN_DIV, so div-1 cannot underflow.
    assign tc = (count_q == div - 1'b1);

endmodule

// File: rtl/tick_rate_ctrl.sv
// Run/stop controller for the clock-division resource: tick enable, clk_out,
// burst mode and a one-deep pending config applied on period boundaries.
//
// Config handshake: a transfer happens on a rising clk edge where
// cfg_valid && cfg_ready; cfg_ready is high whenever the pending slot is empty.
module tick_rate_ctrl
    import tick_rate_ctrl_pkg::*;
#(
    parameter int CNT_W       = 25,
    parameter int DEFAULT_DIV = tick_rate_ctrl_pkg::DEFAULT_DIV,
    parameter int BURST_W     = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic               start,
    input  logic               stop,
    output logic               tick,
    output logic               clk_out,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] tick_count
);

    state_t             state_q,      state_d;
    logic [CNT_W-1:0]   div_active_q, div_active_d;
    logic [CNT_W-1:0]   pend_div_q,   pend_div_d;
    logic               pend_full_q,  pend_full_d;
    logic [BURST_W-1:0] burst_cfg_q,  burst_cfg_d;
    logic [BURST_W-1:0] burst_left_q, burst_left_d;
    logic               clk_out_q,    clk_out_d;
    logic [BURST_W-1:0] tick_count_q, tick_count_d;

    logic               cnt_clr;
    logic               cnt_en;
    logic               cnt_tc;
    logic               accept;
    logic               tick_w;
    logic [CNT_W-1:0]   cfg_div_c;

    tick_counter #(
        .CNT_W (CNT_W)
    ) u_tick_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .div   (div_active_q),
        .tc    (cnt_tc)
    );

    // Handshake, clamped request and tick qualification (stop suppresses a tick).
    always_comb begin
        accept    = cfg_valid && !pend_full_q;
        cfg_div_c = (cfg_div < CNT_W'(MIN_DIV)) ? CNT_W'(MIN_DIV) : cfg_div;
        tick_w    = (state_q == ST_RUN) && cnt_tc && !stop;
    end

    // Next-state and config application for the run/stop FSM.
    always_comb begin
        state_d      = state_q;
        div_active_d = div_active_q;
        pend_div_d   = pend_div_q;
        pend_full_d  = pend_full_q;
        burst_cfg_d  = burst_cfg_q;
        burst_left_d = burst_left_q;
        clk_out_d    = clk_out_q;
        tick_count_d = tick_count_q;
        cnt_clr      = 1'b0;
        cnt_en       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    div_active_d = cfg_div_c;
                    burst_cfg_d  = cfg_burst;
                end
                if (start && !stop) begin
                    state_d      = ST_RUN;
                    cnt_clr      = 1'b1;
                    tick_count_d = '0;
                    burst_left_d = burst_cfg_q;
                end
            end

            ST_RUN: begin
                // Burst length is latched at start, so a new one just waits here.
                if (accept) begin
                    burst_cfg_d = cfg_burst;
                end
                if (stop) begin
                    // Leave IDLE with no pending value: apply whatever was offered.
                    state_d     = ST_IDLE;
                    cnt_clr     = 1'b1;
                    clk_out_d   = 1'b0;
                    pend_full_d = 1'b0;
                    if (accept) begin
                        div_active_d = cfg_div_c;
                    end else if (pend_full_q) begin
                        div_active_d = pend_div_q;
                    end
                end else begin
                    if (tick_w) begin
                        cnt_clr      = 1'b1;
                        clk_out_d    = !clk_out_q;
                        tick_count_d = tick_count_q + 1'b1;
                        if (pend_full_q) begin
                            div_active_d = pend_div_q;
                            pend_full_d  = 1'b0;
                        end
                        // burst_left of zero means continuous mode.
                        if (burst_left_q != '0) begin
                            burst_left_d = burst_left_q - 1'b1;
                            if (burst_left_q == BURST_W'(1)) begin
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                    // Pending slot is empty whenever accept is high.
                    if (accept) begin
                        pend_div_d  = cfg_div_c;
                        pend_full_d = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                if (accept) begin
                    div_active_d = cfg_div_c;
                    burst_cfg_d  = cfg_burst;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller registers; reset discards any pending config.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            div_active_q <= CNT_W'(DEFAULT_DIV);
            pend_div_q   <= '0;
            pend_full_q  <= 1'b0;
            burst_cfg_q  <= '0;
            burst_left_q <= '0;
            clk_out_q    <= 1'b0;
            tick_count_q <= '0;
        end else begin
            state_q      <= state_d;
            div_active_q <= div_active_d;
            pend_div_q   <= pend_div_d;
            pend_full_q  <= pend_full_d;
            burst_cfg_q  <= burst_cfg_d;
            burst_left_q <= burst_left_d;
            clk_out_q    <= clk_out_d;
            tick_count_q <= tick_count_d;
        end
    end

    assign cfg_ready  = !pend_full_q;
    assign tick       = tick_w;
    assign clk_out    = clk_out_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = (state_q == ST_DONE);
    assign tick_count = tick_count_q;

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Bench for tick_rate_ctrl: directed scenarios plus random traffic, all run in
// lockstep against a behavioural model of the run/stop/config rules.
module tb_tick_rate_ctrl;

    localparam int CNT_W          = 25;
    localparam int BURST_W        = 8;
    localparam int TB_DEFAULT_DIV = 12;

    logic               clk = 1'b0;
    logic               reset;
    logic [CNT_W-1:0]   cfg_div;
    logic [BURST_W-1:0] cfg_burst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic               start;
    logic               stop;
    logic               tick;
    logic               clk_out;
    logic               busy;
    logic               done;
    logic [BURST_W-1:0] tick_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int done_cnt = 0;
    int tick_cyc[$];

    // Behavioural model: mode, position within the period, active/pending period.
    int               m_mode;    // 0 idle, 1 running, 2 burst just finished
    int               m_phase;
    int               m_div;
    int               m_pdiv;
    bit               m_pend;
    int               m_bcfg;
    int               m_left;
    bit               m_clk;
    logic [BURST_W-1:0] m_tc;

    tick_rate_ctrl #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (TB_DEFAULT_DIV),
        .BURST_W     (BURST_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_div    (cfg_div),
        .cfg_burst  (cfg_burst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .start      (start),
        .stop       (stop),
        .tick       (tick),
        .clk_out    (clk_out),
        .busy       (busy),
        .done       (done),
        .tick_count (tick_count)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic model_reset();
        m_mode  = 0;
        m_phase = 0;
        m_div   = TB_DEFAULT_DIV;
        m_pdiv  = 0;
        m_pend  = 0;
        m_bcfg  = 0;
        m_left  = 0;
        m_clk   = 0;
        m_tc    = '0;
    endtask

    // One clock: compare outputs against the model for the current inputs,
    // advance the model, then move to just after the next rising edge.
    task automatic cycle();
        bit e_tick;
        bit acc;
        int cd;
        #1;
        e_tick = (m_mode == 1) && (m_phase == m_div - 1) && !stop;
        checks++;
        if (tick !== e_tick) begin
            errors++;
            $display("FAIL tick cyc=%0d got=%b exp=%b", cyc, tick, e_tick);
        end
        checks++;
        if (clk_out !== m_clk) begin
            errors++;
            $display("FAIL clk_out cyc=%0d got=%b exp=%b", cyc, clk_out, m_clk);
        end
        checks++;
        if (busy !== (m_mode == 1)) begin
            errors++;
            $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, (m_mode == 1));
        end
        checks++;
        if (done !== (m_mode == 2)) begin
            errors++;
            $display("FAIL done cyc=%0d got=%b exp=%b", cyc, done, (m_mode == 2));
        end
        checks++;
        if (tick_count !== m_tc) begin
            errors++;
            $display("FAIL tick_count cyc=%0d got=%0d exp=%0d", cyc, tick_count, m_tc);
        end
        checks++;
        if (cfg_ready !== !m_pend) begin
            errors++;
            $display("FAIL cfg_ready cyc=%0d got=%b exp=%b", cyc, cfg_ready, !m_pend);
        end
        if (tick === 1'b1) tick_cyc.push_back(cyc);
        if (done === 1'b1) done_cnt++;

        acc = cfg_valid && !m_pend;
        cd  = (cfg_div < 2) ? 2 : int'(cfg_div);
        if (m_mode == 0) begin
            if (start && !stop) begin
                m_mode  = 1;
                m_phase = 0;
                m_tc    = '0;
                m_left  = m_bcfg;
            end
            if (acc) begin
                m_div  = cd;
                m_bcfg = cfg_burst;
            end
        end else if (m_mode == 2) begin
            m_mode = 0;
            if (acc) begin
                m_div  = cd;
                m_bcfg = cfg_burst;
            end
        end else begin
            if (acc) m_bcfg = cfg_burst;
            if (stop) begin
                m_mode  = 0;
                m_phase = 0;
                m_clk   = 0;
                if (acc) m_div = cd;
                else if (m_pend) m_div = m_pdiv;
                m_pend = 0;
            end else begin
                if (e_tick) begin
                    m_phase = 0;
                    m_clk   = !m_clk;
                    m_tc    = m_tc + 1'b1;
                    if (m_pend) begin
                        m_div  = m_pdiv;
                        m_pend = 0;
                    end
                    if (m_left != 0) begin
                        m_left--;
                        if (m_left == 0) m_mode = 2;
                    end
                end else begin
                    m_phase++;
                end
                if (acc) begin
                    m_pdiv = cd;
                    m_pend = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic cfg_idle(input int d, input int b);
        cfg_valid = 1'b1;
        cfg_div   = CNT_W'(d);
        cfg_burst = BURST_W'(b);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic start_run();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic stop_run();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
    endtask

    task automatic check_spacing(input string name, input int s, input int first, input int period, input int n);
        checks++;
        if (tick_cyc.size() < n) begin
            errors++;
            $display("FAIL %s_count got=%0d exp>=%0d", name, tick_cyc.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                checks++;
                if (tick_cyc[i] != s + first + i * period) begin
                    errors++;
                    $display("FAIL %s_tick%0d got=%0d exp=%0d", name, i, tick_cyc[i] - s, first + i * period);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cfg_valid = 1'b0;
        cfg_div = '0;
        cfg_burst = '0;
        start = 1'b0;
        stop = 1'b0;
        model_reset();
        #2;
        checks++;
        if ({tick, clk_out, busy, done, tick_count, cfg_ready} !== {4'b0000, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_values got=%b exp=%b", {tick, clk_out, busy, done, tick_count, cfg_ready}, {4'b0000, 8'd0, 1'b1});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(2);
    endtask

    task automatic test_continuous();
        int s;
        cfg_idle(4, 0);
        s = cyc;
        start_run();
        tick_cyc.delete();
        run(40);
        check_spacing("cont", s, 4, 4, 10);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL cont_busy got=%b exp=1", busy);
        end
        stop_run();
        run(2);
    endtask

    task automatic test_burst();
        int s;
        cfg_idle(5, 3);
        s = cyc;
        start_run();
        tick_cyc.delete();
        done_cnt = 0;
        run(25);
        check_spacing("burst", s, 5, 5, 3);
        checks++;
        if (tick_cyc.size() != 3) begin
            errors++;
            $display("FAIL burst_ticks got=%0d exp=3", tick_cyc.size());
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL burst_done got=%0d exp=1", done_cnt);
        end
        checks++;
        if (tick_count !== 8'd3 || busy !== 1'b0) begin
            errors++;
            $display("FAIL burst_end got=%0d/%b exp=3/0", tick_count, busy);
        end
    endtask

    task automatic test_reconfig();
        int s;
        cfg_idle(10, 0);
        s = cyc;
        start_run();
        tick_cyc.delete();
        run(3);
        cfg_valid = 1'b1;
        cfg_div = CNT_W'(3);
        cycle();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reconf_ready_drop got=%b exp=0", cfg_ready);
        end
        while (cyc < s + 30) begin
            if (cyc == s + 10 || cyc == s + 11) begin
                checks++;
                if (cfg_ready !== (cyc == s + 11)) begin
                    errors++;
                    $display("FAIL reconf_ready cyc=+%0d got=%b exp=%b", cyc - s, cfg_ready, (cyc == s + 11));
                end
            end
            cycle();
        end
        check_spacing("reconf_first", s, 10, 10, 1);
        tick_cyc.pop_front();
        check_spacing("reconf_next", s, 13, 3, 5);
        stop_run();
        run(2);
    endtask

    task automatic test_clamp();
        int s;
        for (int d = 0; d < 2; d++) begin
            cfg_idle(d, 0);
            s = cyc;
            start_run();
            tick_cyc.delete();
            run(10);
            check_spacing(d == 0 ? "clamp0" : "clamp1", s, 2, 2, 5);
            stop_run();
            run(1);
        end
    endtask

    task automatic test_stop_tc();
        cfg_idle(4, 0);
        start_run();
        run(4);
        stop = 1'b1;
        #1;
        checks++;
        if (tick !== 1'b0) begin
            errors++;
            $display("FAIL stop_tc_tick got=%b exp=0", tick);
        end
        cycle();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || clk_out !== 1'b0) begin
            errors++;
            $display("FAIL stop_tc_idle got=%b/%b exp=0/0", busy, clk_out);
        end
        start = 1'b1;
        stop = 1'b1;
        cycle();
        start = 1'b0;
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_stop_busy got=%b exp=0", busy);
        end
        run(3);
    endtask

    task automatic test_reset_mid();
        int s;
        cfg_idle(6, 5);
        start_run();
        run(8);
        cfg_valid = 1'b1;
        cfg_div = CNT_W'(3);
        cycle();
        cfg_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({tick, clk_out, busy, done, tick_count, cfg_ready} !== {4'b0000, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid got=%b exp=%b", {tick, clk_out, busy, done, tick_count, cfg_ready}, {4'b0000, 8'd0, 1'b1});
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        run(2);
        s = cyc;
        start_run();
        tick_cyc.delete();
        run(30);
        check_spacing("post_reset", s, TB_DEFAULT_DIV, TB_DEFAULT_DIV, 2);
        stop_run();
        run(2);
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            cfg_valid = ($urandom_range(0, 4) == 0);
            cfg_div   = CNT_W'($urandom_range(0, 9));
            cfg_burst = BURST_W'($urandom_range(0, 4));
            start     = ($urandom_range(0, 7) == 0);
            stop      = ($urandom_range(0, 39) == 0);
            cycle();
        end
        cfg_valid = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        run(5);
    endtask

    // Long continuous run so tick_count wraps past 255.
    task automatic test_wrap();
        cfg_idle(2, 0);
        start_run();
        run(530);
        checks++;
        if (tick_count !== 8'd9) begin
            errors++;
            $display("FAIL wrap_count got=%0d exp=9", tick_count);
        end
        stop_run();
        run(1);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_burst();
        test_reconfig();
        test_clamp();
        test_stop_tc();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
